// File: rtl/decode_stage.sv
// RV32I decode stage: registers the fetched instruction, classifies it,
// builds the immediate and generates forwarding, load-use stall and bubbles.
module decode_stage #(
    parameter int AddrWidth  = 32,
    parameter int DataWidth  = 32,
    parameter int StateWidth = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instValid,
    input  logic [DataWidth-1:0]  inst,
    input  logic [AddrWidth-1:0]  instPC,
    input  logic                  flush,
    output logic [StateWidth-1:0] state,
    output logic [DataWidth-1:0]  imm,
    output logic [2:0]            func3,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [4:0]            rd,
    output logic [AddrWidth-1:0]  PC,
    output logic [1:0]            forwordA,
    output logic [1:0]            forwordB,
    output logic                  stall,
    output logic                  illegal
);

    localparam logic [StateWidth-1:0] S_IDLE = StateWidth'(0);
    localparam logic [StateWidth-1:0] S_RW   = StateWidth'(1);
    localparam logic [StateWidth-1:0] S_MRRW = StateWidth'(2);
    localparam logic [StateWidth-1:0] S_MW   = StateWidth'(3);
    localparam logic [StateWidth-1:0] S_PCSW = StateWidth'(4);
    localparam logic [StateWidth-1:0] S_PCW  = StateWidth'(5);
    localparam logic [StateWidth-1:0] S_LUI  = StateWidth'(6);

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X
    } fmt_e;

    logic [6:0]            w_opcode;
    logic [StateWidth-1:0] w_state;
    fmt_e                  w_fmt;
    logic                  w_illegal;
    logic [DataWidth-1:0]  w_imm;
    logic                  w_use1;
    logic                  w_use2;
    logic                  w_wr;
    logic [4:0]            w_rs1;
    logic [4:0]            w_rs2;
    logic [4:0]            w_rd;
    logic                  w_hazard;
    logic                  w_bubble;

    logic [StateWidth-1:0] r_state;
    logic [DataWidth-1:0]  r_imm;
    logic [2:0]            r_func3;
    logic [4:0]            r_rs1;
    logic [4:0]            r_rs2;
    logic [4:0]            r_rd;
    logic [AddrWidth-1:0]  r_pc;
    logic [1:0]            r_fwdA;
    logic [1:0]            r_fwdB;
    logic                  r_illegal;
    logic [4:0]            r_rdE;
    logic [4:0]            r_rdM;

    assign w_opcode = inst[6:0];

    always_comb begin
        w_state   = S_IDLE;
        w_fmt     = FMT_X;
        w_illegal = 1'b0;
        case (w_opcode)
            7'b0110011: begin w_state = S_RW;   w_fmt = FMT_R; end
            7'b0010011: begin w_state = S_RW;   w_fmt = FMT_I; end
            7'b0010111: begin w_state = S_RW;   w_fmt = FMT_U; end
            7'b0000011: begin w_state = S_MRRW; w_fmt = FMT_I; end
            7'b0100011: begin w_state = S_MW;   w_fmt = FMT_S; end
            7'b1100011: begin w_state = S_PCSW; w_fmt = FMT_B; end
            7'b1101111: begin w_state = S_PCW;  w_fmt = FMT_J; end
            7'b1100111: begin w_state = S_PCW;  w_fmt = FMT_I; end
            7'b0110111: begin w_state = S_LUI;  w_fmt = FMT_U; end
            default:    w_illegal = 1'b1;
        endcase
    end

    // Register fields that are really immediate bits are masked to 0.
    always_comb begin
        w_imm  = '0;
        w_use1 = 1'b0;
        w_use2 = 1'b0;
        w_wr   = 1'b0;
        case (w_fmt)
            FMT_R: begin
                w_use1 = 1'b1;
                w_use2 = 1'b1;
                w_wr   = 1'b1;
            end
            FMT_I: begin
                w_imm  = {{20{inst[31]}}, inst[31:20]};
                w_use1 = 1'b1;
                w_wr   = 1'b1;
            end
            FMT_S: begin
                w_imm  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                w_use1 = 1'b1;
                w_use2 = 1'b1;
            end
            FMT_B: begin
                w_imm  = {{19{inst[31]}}, inst[31], inst[7],
                          inst[30:25], inst[11:8], 1'b0};
                w_use1 = 1'b1;
                w_use2 = 1'b1;
            end
            FMT_U: begin
                w_imm = {inst[31:12], 12'b0};
                w_wr  = 1'b1;
            end
            FMT_J: begin
                w_imm = {{11{inst[31]}}, inst[31], inst[19:12],
                         inst[20], inst[30:21], 1'b0};
                w_wr  = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_rs1 = w_use1 ? inst[19:15] : 5'd0;
    assign w_rs2 = w_use2 ? inst[24:20] : 5'd0;
    assign w_rd  = w_wr   ? inst[11:7]  : 5'd0;

    // r_rd != 0 guarantees masked-out sources never match.
    assign w_hazard = (r_state == S_MRRW) && (r_rd != 5'd0)
                   && ((w_rs1 == r_rd) || (w_rs2 == r_rd));
    assign stall    = instValid && !flush && w_hazard;
    assign w_bubble = !instValid || flush || stall;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] rd_e,
        input logic [4:0] rd_m
    );
        if (src != 5'd0 && src == rd_e)
            return 2'b01;
        else if (src != 5'd0 && src == rd_m)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_imm     <= '0;
            r_func3   <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_pc      <= '0;
            r_fwdA    <= '0;
            r_fwdB    <= '0;
            r_illegal <= 1'b0;
            r_rdE     <= '0;
            r_rdM     <= '0;
        end else begin
            r_pc  <= instPC;
            r_rdM <= r_rdE;
            if (w_bubble) begin
                r_state   <= S_IDLE;
                r_imm     <= '0;
                r_func3   <= '0;
                r_rs1     <= '0;
                r_rs2     <= '0;
                r_rd      <= '0;
                r_fwdA    <= '0;
                r_fwdB    <= '0;
                r_illegal <= 1'b0;
                r_rdE     <= '0;
            end else begin
                r_state   <= w_state;
                r_imm     <= w_imm;
                r_func3   <= inst[14:12];
                r_rs1     <= w_rs1;
                r_rs2     <= w_rs2;
                r_rd      <= w_rd;
                r_fwdA    <= fwd_sel(w_rs1, r_rdE, r_rdM);
                r_fwdB    <= fwd_sel(w_rs2, r_rdE, r_rdM);
                r_illegal <= w_illegal;
                r_rdE     <= w_rd;
            end
        end
    end

    assign state    = r_state;
    assign imm      = r_imm;
    assign func3    = r_func3;
    assign rs1      = r_rs1;
    assign rs2      = r_rs2;
    assign rd       = r_rd;
    assign PC       = r_pc;
    assign forwordA = r_fwdA;
    assign forwordB = r_fwdB;
    assign illegal  = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed vectors for decode,
// forwarding, load-use stall, flush and async reset.
module tb_decode_stage;

    logic        clk;
    logic        reset;
    logic        instValid;
    logic [31:0] inst;
    logic [31:0] instPC;
    logic        flush;
    logic [3:0]  state;
    logic [31:0] imm;
    logic [2:0]  func3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] PC;
    logic [1:0]  forwordA;
    logic [1:0]  forwordB;
    logic        stall;
    logic        illegal;

    int n_checks;
    int n_errors;

    decode_stage dut (
        .clk       (clk),
        .reset     (reset),
        .instValid (instValid),
        .inst      (inst),
        .instPC    (instPC),
        .flush     (flush),
        .state     (state),
        .imm       (imm),
        .func3     (func3),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .PC        (PC),
        .forwordA  (forwordA),
        .forwordB  (forwordB),
        .stall     (stall),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] i,
                         input logic [31:0] pc, input logic f);
        instValid = v;
        inst      = i;
        instPC    = pc;
        flush     = f;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ADDI  = 32'hFFB00093;
    localparam logic [31:0] LW    = 32'h00812283;
    localparam logic [31:0] ADD6  = 32'h00128333;
    localparam logic [31:0] ADD3  = 32'h002081B3;
    localparam logic [31:0] SUB4  = 32'h40318233;
    localparam logic [31:0] BEQ   = 32'hFE000CE3;
    localparam logic [31:0] BADOP = 32'h0000007F;
    localparam logic [31:0] LUI   = 32'h123453B7;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        instValid = 1'b0;
        inst      = '0;
        instPC    = '0;
        flush     = 1'b0;
        tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_imm", imm, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        reset = 1'b0;

        // addi x1,x0,-5
        drive(1'b1, ADDI, 32'h100, 1'b0);
        check("addi_stall", 32'(stall), 32'd0);
        tick();
        check("addi_state", 32'(state), 32'd1);
        check("addi_imm", imm, 32'hFFFFFFFB);
        check("addi_rd", 32'(rd), 32'd1);
        check("addi_rs1", 32'(rs1), 32'd0);
        check("addi_fwdA", 32'(forwordA), 32'd0);
        check("addi_pc", PC, 32'h100);

        // lw x5,8(x2) then add x6,x5,x1: one stall, one bubble
        drive(1'b1, LW, 32'h104, 1'b0);
        check("lw_stall", 32'(stall), 32'd0);
        tick();
        check("lw_state", 32'(state), 32'd2);
        check("lw_rd", 32'(rd), 32'd5);
        check("lw_imm", imm, 32'd8);
        check("lw_func3", 32'(func3), 32'd2);
        check("lw_rs1", 32'(rs1), 32'd2);
        drive(1'b1, ADD6, 32'h108, 1'b0);
        check("lu_stall", 32'(stall), 32'd1);
        tick();
        check("bub_state", 32'(state), 32'd0);
        check("bub_rd", 32'(rd), 32'd0);
        check("bub_pc", PC, 32'h108);
        check("bub_stall", 32'(stall), 32'd0);
        tick();
        check("add6_state", 32'(state), 32'd1);
        check("add6_rd", 32'(rd), 32'd6);
        check("add6_rs1", 32'(rs1), 32'd5);
        check("add6_rs2", 32'(rs2), 32'd1);
        check("add6_fwdA", 32'(forwordA), 32'd2);
        check("add6_fwdB", 32'(forwordB), 32'd0);

        // add x3,x1,x2 ; sub x4,x3,x3
        drive(1'b1, ADD3, 32'h10C, 1'b0);
        tick();
        check("add3_rd", 32'(rd), 32'd3);
        drive(1'b1, SUB4, 32'h110, 1'b0);
        check("sub_stall", 32'(stall), 32'd0);
        tick();
        check("sub_rd", 32'(rd), 32'd4);
        check("sub_fwdA", 32'(forwordA), 32'd1);
        check("sub_fwdB", 32'(forwordB), 32'd1);

        // beq x0,x0,-8 then lw and a flushed dependent add
        drive(1'b1, BEQ, 32'h200, 1'b0);
        tick();
        check("beq_state", 32'(state), 32'd4);
        check("beq_imm", imm, 32'hFFFFFFF8);
        check("beq_rd", 32'(rd), 32'd0);
        drive(1'b1, LW, 32'h204, 1'b0);
        tick();
        check("lw2_state", 32'(state), 32'd2);
        drive(1'b1, ADD6, 32'h208, 1'b1);
        check("fl_stall", 32'(stall), 32'd0);
        tick();
        check("fl_state", 32'(state), 32'd0);
        check("fl_rd", 32'(rd), 32'd0);
        check("fl_rs1", 32'(rs1), 32'd0);
        check("fl_pc", PC, 32'h208);

        // unknown opcode, then lui x7,0x12345
        drive(1'b1, BADOP, 32'h300, 1'b0);
        tick();
        check("bad_state", 32'(state), 32'd0);
        check("bad_illegal", 32'(illegal), 32'd1);
        drive(1'b1, LUI, 32'h304, 1'b0);
        tick();
        check("lui_illegal", 32'(illegal), 32'd0);
        check("lui_state", 32'(state), 32'd6);
        check("lui_imm", imm, 32'h12345000);
        check("lui_rd", 32'(rd), 32'd7);

        // async reset while a load-use stall is pending
        drive(1'b1, LW, 32'h400, 1'b0);
        tick();
        drive(1'b1, ADD6, 32'h404, 1'b0);
        check("pre_rst_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        #1;
        check("ar_state", 32'(state), 32'd0);
        check("ar_rd", 32'(rd), 32'd0);
        check("ar_imm", imm, 32'd0);
        check("ar_pc", PC, 32'd0);
        check("ar_stall", 32'(stall), 32'd0);
        #1;
        reset = 1'b0;
        drive(1'b1, ADDI, 32'h500, 1'b0);
        tick();
        check("post_state", 32'(state), 32'd1);
        check("post_imm", imm, 32'hFFFFFFFB);
        check("post_fwdA", 32'(forwordA), 32'd0);
        check("post_pc", PC, 32'h500);

        drive(1'b0, '0, '0, 1'b0);
        tick();
        check("idle_state", 32'(state), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
